// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU. Logic, shift and add/sub operations finish in one
// registered cycle; unsigned multiply (low/high) and divide/remainder iterate
// one bit per cycle behind a start/busy/done handshake.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             z
);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpAnd   = 4'b0001;
  localparam logic [3:0] OpXor   = 4'b0010;
  localparam logic [3:0] OpSll   = 4'b0011;
  localparam logic [3:0] OpSub   = 4'b0100;
  localparam logic [3:0] OpOr    = 4'b0101;
  localparam logic [3:0] OpLui   = 4'b0110;
  localparam logic [3:0] OpSrl   = 4'b0111;
  localparam logic [3:0] OpMulhu = 4'b1000;
  localparam logic [3:0] OpMul   = 4'b1011;
  localparam logic [3:0] OpDivu  = 4'b1100;
  localparam logic [3:0] OpRemu  = 4'b1101;
  localparam logic [3:0] OpSra   = 4'b1111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e               state_q, state_d;
  // Mul: {partial product high, remaining multiplier bits}.
  // Div: {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand (mul) or divisor (div)
  logic                 hi_q, hi_d;       // deliver high half / remainder
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic                 z_q, z_d;
  logic                 done_q, done_d;

  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  assign shamt = a[SHW-1:0];

  // Single-cycle operation result, decoded from the live opcode.
  always_comb begin
    alu_res = '0;
    case (aluc)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpLui:   alu_res = b << (WIDTH / 2);
      OpSll:   alu_res = b << shamt;
      OpSrl:   alu_res = b >> shamt;
      OpSra:   alu_res = $signed(b) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    // Only used when div_ge, where the true difference fits in WIDTH bits.
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  // Next-state and datapath control. The final iteration writes s/z directly so
  // that the FIN cycle is the done cycle with the result already visible.
  always_comb begin
    logic [WIDTH-1:0] res;
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    z_d     = z_q;
    done_d  = 1'b0;
    res     = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (aluc == OpMul || aluc == OpMulhu) begin
            opnd_d  = a;
            acc_d   = {{WIDTH{1'b0}}, b};
            hi_d    = (aluc == OpMulhu);
            cnt_d   = SHW'(WIDTH - 1);
            state_d = StMul;
          end else if (aluc == OpDivu || aluc == OpRemu) begin
            opnd_d  = b;
            acc_d   = {{WIDTH{1'b0}}, a};
            hi_d    = (aluc == OpRemu);
            cnt_d   = SHW'(WIDTH - 1);
            state_d = StDiv;
          end else begin
            s_d    = alu_res;
            z_d    = (alu_res == '0);
            done_d = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          res     = hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
          s_d     = res;
          z_d     = (res == '0);
          done_d  = 1'b1;
          state_d = StFin;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          res     = hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
          s_d     = res;
          z_d     = (res == '0);
          done_d  = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        // start is ignored here; a new op is accepted from the next cycle.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      z_q     <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == StMul) || (state_q == StDiv);
  assign done = done_q;
  assign s    = s_q;
  assign z    = z_q;

endmodule
